// File: rtl/rsa_modexp_core.sv
// Modular exponentiation msg^exp mod N using one shared bit-serial radix-2
// Montgomery multiplier; the exponent is scanned LSB-first and stops at its top set bit.
module rsa_modexp_core #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
);
  localparam int TW = WIDTH + 2;
  localparam int SW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, FAULT, PRE_X, PRE_A, MUL, SQR, POST, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     x_q, a_q, n_q, r2_q;
  logic [EXP_WIDTH-1:0] e_sh, e_nxt;
  logic [TW-1:0]        t_q, t_step;
  logic [CW-1:0]        cnt;
  logic                 fault_q;

  logic [WIDTH-1:0] op_a, op_b, op_a_sh, mm_out;
  logic [SW-1:0]    sum_a, sum_n;
  logic [TW-1:0]    t_fin;
  logic             in_op, last, accept, busy_d, done_d;
  state_t           scan_st;

  // operand routing for the shared multiplier
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state)
      PRE_X:   begin op_a = x_q;                 op_b = r2_q; end
      PRE_A:   begin op_a = WIDTH'(1);           op_b = r2_q; end
      MUL:     begin op_a = a_q;                 op_b = x_q;  end
      SQR:     begin op_a = x_q;                 op_b = x_q;  end
      POST:    begin op_a = a_q;                 op_b = WIDTH'(1); end
      default: begin op_a = '0;                  op_b = '0;   end
    endcase
  end

  assign in_op   = (state == PRE_X) || (state == PRE_A) || (state == MUL) ||
                   (state == SQR) || (state == POST);
  assign last    = in_op && (cnt == CW'(WIDTH));
  assign accept  = (state == IDLE) && start;
  assign op_a_sh = op_a >> cnt;

  // one Montgomery step: add a[i]*b, make even with N, halve
  always_comb begin
    sum_a  = {1'b0, t_q} + (op_a_sh[0] ? {{(SW-WIDTH){1'b0}}, op_b} : '0);
    sum_n  = sum_a[0] ? sum_a + {{(SW-WIDTH){1'b0}}, n_q} : sum_a;
    t_step = sum_n[SW-1:1];
    t_fin  = (t_q >= {2'b00, n_q}) ? t_q - {2'b00, n_q} : t_q;
    mm_out = t_fin[WIDTH-1:0];
  end

  // SCAN is folded into the last cycle of PRE_A / SQR
  always_comb begin
    e_nxt   = (state == SQR) ? (e_sh >> 1) : e_sh;
    scan_st = (e_nxt == '0) ? POST : (e_nxt[0] ? MUL : SQR);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = modulus[0] ? PRE_X : FAULT;
      FAULT:   state_nxt = DONE;
      PRE_X:   if (last) state_nxt = PRE_A;
      PRE_A:   if (last) state_nxt = scan_st;
      MUL:     if (last) state_nxt = SQR;
      SQR:     if (last) state_nxt = scan_st;
      POST:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state != IDLE) && (state != DONE);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      a_q     <= '0;
      n_q     <= '0;
      r2_q    <= '0;
      e_sh    <= '0;
      t_q     <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        x_q     <= msg;
        r2_q    <= r2;
        n_q     <= modulus;
        e_sh    <= exp;
        a_q     <= '0;
        t_q     <= '0;
        cnt     <= '0;
        fault_q <= ~modulus[0];
        err     <= 1'b0;
        result  <= '0;
      end
      if (in_op) begin
        if (last) begin
          t_q <= '0;
          cnt <= '0;
          if ((state == PRE_X) || (state == SQR)) x_q <= mm_out;
          else                                    a_q <= mm_out;
          if (state == SQR) e_sh <= e_sh >> 1;
        end else begin
          t_q <= t_step;
          cnt <= cnt + 1'b1;
        end
      end
      if (state == DONE) begin
        result <= fault_q ? '0 : a_q;
        err    <= fault_q;
      end
    end
  end

endmodule
